// File: rtl/magnitude_estimator.sv
// Streaming complex-to-magnitude estimator (mode-selectable) with per-frame peak tracking.
// Latency 3 cycles; one global enable stalls all stages together when the output is held.
module magnitude_estimator #(
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = DATA_WIDTH,
    parameter int TAG_WIDTH  = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [2*DATA_WIDTH-1:0] i_fft_complex,
    input  logic [1:0]              i_mode,
    input  logic [TAG_WIDTH-1:0]    i_tag,
    input  logic                    i_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [OUT_WIDTH-1:0]    o_magnitude,
    output logic [TAG_WIDTH-1:0]    o_tag,
    output logic                    o_last,
    output logic                    o_peak_valid,
    output logic [OUT_WIDTH-1:0]    o_peak_mag,
    output logic [TAG_WIDTH-1:0]    o_peak_tag
);
    localparam int EW = DATA_WIDTH + 2;

    logic en;
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    logic [DATA_WIDTH-1:0] re, im, re_abs, im_abs;
    assign re = i_fft_complex[2*DATA_WIDTH-1:DATA_WIDTH];
    assign im = i_fft_complex[DATA_WIDTH-1:0];
    // Unsigned negate maps the most negative input to exactly 2^(DATA_WIDTH-1).
    assign re_abs = re[DATA_WIDTH-1] ? ('0 - re) : re;
    assign im_abs = im[DATA_WIDTH-1] ? ('0 - im) : im;

    logic                  s1_vld, s1_last, s2_vld, s2_last;
    logic [1:0]            s1_mode, s2_mode;
    logic [TAG_WIDTH-1:0]  s1_tag, s2_tag;
    logic [DATA_WIDTH-1:0] s1_re, s1_im, s2_max, s2_min;

    logic [EW-1:0] mx, mn, est_a, est_b, est;
    logic [OUT_WIDTH-1:0] sat_mag;
    assign mx = {2'b00, s2_max};
    assign mn = {2'b00, s2_min};

    always_comb begin
        est_a = mx + (mn >> 3);
        est_b = mx - (mx >> 3) + (mn >> 1);
        case (s2_mode)
            2'd1:    est = mx + (mn >> 2);
            2'd2:    est = (est_a > est_b) ? est_a : est_b;
            default: est = mx + (mn >> 2) + (mn >> 3);
        endcase
    end

    assign sat_mag = (|est[EW-1:OUT_WIDTH]) ? '1 : est[OUT_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld      <= 1'b0;
            s1_last     <= 1'b0;
            s1_mode     <= '0;
            s1_tag      <= '0;
            s1_re       <= '0;
            s1_im       <= '0;
            s2_vld      <= 1'b0;
            s2_last     <= 1'b0;
            s2_mode     <= '0;
            s2_tag      <= '0;
            s2_max      <= '0;
            s2_min      <= '0;
            o_valid     <= 1'b0;
            o_magnitude <= '0;
            o_tag       <= '0;
            o_last      <= 1'b0;
        end else if (en) begin
            s1_vld      <= i_valid;
            s1_last     <= i_last;
            s1_mode     <= i_mode;
            s1_tag      <= i_tag;
            s1_re       <= re_abs;
            s1_im       <= im_abs;
            s2_vld      <= s1_vld;
            s2_last     <= s1_last;
            s2_mode     <= s1_mode;
            s2_tag      <= s1_tag;
            s2_max      <= (s1_re >= s1_im) ? s1_re : s1_im;
            s2_min      <= (s1_re >= s1_im) ? s1_im : s1_re;
            o_valid     <= s2_vld;
            o_magnitude <= sat_mag;
            o_tag       <= s2_tag;
            o_last      <= s2_last;
        end
    end

    // Running peak of the current frame; strict compare keeps the earliest bin on ties.
    logic                 run_active, take;
    logic [OUT_WIDTH-1:0] run_mag, cand_mag;
    logic [TAG_WIDTH-1:0] run_tag, cand_tag;
    assign take     = !run_active || (o_magnitude > run_mag);
    assign cand_mag = take ? o_magnitude : run_mag;
    assign cand_tag = take ? o_tag : run_tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_active   <= 1'b0;
            run_mag      <= '0;
            run_tag      <= '0;
            o_peak_valid <= 1'b0;
            o_peak_mag   <= '0;
            o_peak_tag   <= '0;
        end else begin
            o_peak_valid <= 1'b0;
            if (o_valid && i_ready) begin
                if (o_last) begin
                    o_peak_valid <= 1'b1;
                    o_peak_mag   <= cand_mag;
                    o_peak_tag   <= cand_tag;
                    run_active   <= 1'b0;
                end else begin
                    run_active   <= 1'b1;
                    run_mag      <= cand_mag;
                    run_tag      <= cand_tag;
                end
            end
        end
    end
endmodule

// File: doc/magnitude_estimator.md
Name: magnitude_estimator

Overview:
- Parametrised, back-pressurable successor to the single-mode FFT magnitude stage. Converts streaming complex FFT bins to approximate magnitudes with a run-time selectable estimator.
- Carries a bin tag and frame-last marker through the pipeline. Tracks the per-frame peak bin for the spectrum display and peak-detect logic downstream of the FFT core.

Parameters:
- DATA_WIDTH, 24, width of signed Re and Im each.
- OUT_WIDTH, DATA_WIDTH, width of unsigned magnitude output (must be <= DATA_WIDTH+1).
- TAG_WIDTH, 10, width of bin index tag.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept input this cycle.
- i_fft_complex  in  2*DATA_WIDTH  {Re, Im}, Re in upper half, two's complement.
- i_mode  in  2  estimator select, captured with each accepted sample.
- i_tag  in  TAG_WIDTH  bin index.
- i_last  in  1  last bin of frame.
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accepts output.
- o_magnitude  out  OUT_WIDTH  estimated magnitude.
- o_tag  out  TAG_WIDTH  tag of o_magnitude.
- o_last  out  1  last flag of o_magnitude.
- o_peak_valid  out  1  one-cycle pulse, frame peak available.
- o_peak_mag  out  OUT_WIDTH  largest magnitude of completed frame.
- o_peak_tag  out  TAG_WIDTH  tag of that magnitude.

Behaviour:
- Reset (async assert, sync release): every valid flag cleared, o_valid=0, o_peak_valid=0. o_magnitude, o_tag, o_last, o_peak_mag and o_peak_tag reset to 0. Running peak state cleared. Reset mid-frame discards all in-flight samples and partial peak state; no pulse is emitted.
- Pipeline: 3 stages, S1 abs, S2 max/min, S3 estimate+saturate. Every stage carries valid, mode, tag and last.
- Global enable en = !o_valid || i_ready; o_ready = en. All stages advance only when en=1, otherwise they hold. No bubbles are inserted and no data is lost under stall.
- Input accepted when i_valid && o_ready. Output handshake occurs when o_valid && i_ready.
- Latency: 3 cycles from acceptance to o_valid with i_ready held high. Throughput is 1 sample/cycle.
- S1: |x| = -x for negative x, computed in DATA_WIDTH unsigned bits; |-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1) exactly.
- S2: max = larger of |Re|, |Im|; equal values are both accepted as either max or min.
- S3, computed in DATA_WIDTH+2 bits with truncating shifts:
  - mode 0: max + (min>>2) + (min>>3).
  - mode 1: max + (min>>2).
  - mode 2: larger of A = max + (min>>3) and B = max - (max>>3) + (min>>1).
  - mode 3: reserved, behaves as mode 0.
- Saturation: if the result exceeds 2^OUT_WIDTH-1, output all ones.
- Peak tracking:
  - Updated on each output handshake. The sample replaces the running peak if it is the first of the frame or strictly greater than the peak; ties keep the earlier bin.
  - On handshake of a sample with o_last=1, the cycle after sets o_peak_valid=1 for one cycle, with o_peak_mag/o_peak_tag including that sample. Running state then restarts for the next frame.
  - o_peak_mag/o_peak_tag hold their value until the next pulse.
  - A frame of one sample (first and last) reports that sample.
- Mode is per-sample. Changing i_mode between samples takes effect exactly on the next accepted sample; in-flight samples are unaffected.

Test Plan:
- DATA_WIDTH=16, i_ready=1, Re=-300, Im=400, modes 0/1/2, tags 1/2/3 -> o_magnitude 512, 475, 500 on three consecutive cycles, 3 cycles after each input, tags matching.
- Re=Im=-32768, mode 0: with OUT_WIDTH=16 -> 45056; with OUT_WIDTH=15 -> saturates to 32767.
- Stream 8 samples, i_ready toggling 1,0,0,1,... with i_valid always 1 -> o_ready mirrors stall. Output sequence equals the unstalled reference with no duplicates or drops; o_tag order 0..7.
- Frame of 5 bins with magnitudes 10, 70, 30, 70, 5 (tags 0..4), last on tag 4 -> single o_peak_valid pulse one cycle after the last handshake, o_peak_mag=70, o_peak_tag=1. The next frame reports independently.
- Stall with last sample held at output (i_ready=0 for 4 cycles) -> no peak pulse until handshake, then exactly one pulse.
- Assert reset_n=0 asynchronously mid-frame with 3 samples in flight -> o_valid, o_peak_valid drop immediately. After release, a new 2-bin frame reports only its own peak.
